mips_run_ctrl: RTL and testbench

Synthesizable run controller for the MIPS core. It replaces a fixed clock/reset script with a parametrised sequence:
- holds the core's reset domains for a programmable time;
- releases them in staggered order;
- runs the core against a cycle budget or until a halt request;
- reports completion or timeout.

It sits between board/bench reset and `MIPS`, driving one reset line per domain.

---
 rtl/mips_run_pkg.sv | 7 +
 rtl/mips_run_ctrl_reset_sync.sv | 13 +
 rtl/mips_run_ctrl.sv | 119 +++++++++++
 tb/tb_mips_run_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mips_run_pkg.sv
// mips_run_pkg: shared FSM encoding and default timing constants for the MIPS run controller.
package mips_run_pkg;
    typedef enum logic [2:0] {IDLE, HOLD, RELEASE, RUN, DONE} state_e;
    localparam int MAX_DOMAINS     = 8;
    localparam int DEF_HOLD_CYCLES = 2;
    localparam int DEF_STAGGER     = 1;
endpackage

// File: rtl/mips_run_ctrl_reset_sync.sv
// reset_sync: 2-flop synchronizer, asserts asynchronously and deasserts on the second clock edge.
module reset_sync (
    input  logic clk,
    input  logic rst_ni,
    output logic rst_no
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_no = sync_q[1];
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequences core reset hold, staggered domain release, budgeted run and completion.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int NUM_DOMAINS = 2,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int BUDGET_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BUDGET_W-1:0]    budget,
    input  logic                   halt_req,
    output logic [NUM_DOMAINS-1:0] cpu_reset,
    output logic                   running,
    output logic                   done,
    output logic                   timeout,
    output logic [BUDGET_W-1:0]    cycle_count
);
    // One counter serves both the hold phase and the release phase.
    localparam int REL_SPAN = (NUM_DOMAINS - 1) * STAGGER;
    localparam int CNT_MAX  = HOLD_CYCLES > REL_SPAN ? HOLD_CYCLES : REL_SPAN;
    localparam int CNT_W    = $clog2(CNT_MAX + 2);

    logic                   rst_sync_n;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BUDGET_W-1:0]    budget_q, budget_d, cc_q, cc_d;
    logic [NUM_DOMAINS-1:0] cpu_reset_q, cpu_reset_d, rel_hit;
    logic                   running_q, running_d, done_q, done_d, timeout_q, timeout_d;
    logic                   expire;

    reset_sync u_reset_sync (
        .clk    (clk),
        .rst_ni (reset),
        .rst_no (rst_sync_n)
    );

    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < NUM_DOMAINS; i++)
            rel_hit[i] = (state_q == RELEASE) && (cnt_q == CNT_W'(i * STAGGER));
    end

    assign expire = (budget_q != '0) && (cc_q == budget_q - BUDGET_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        budget_d    = budget_q;
        cc_d        = cc_q;
        cpu_reset_d = cpu_reset_q & ~rel_hit;
        running_d   = running_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            IDLE, DONE: if (start) begin
                state_d   = HOLD;
                budget_d  = budget;
                cnt_d     = '0;
                cc_d      = '0;
                done_d    = 1'b0;
                timeout_d = 1'b0;
            end
            HOLD: begin
                state_d = (cnt_q == CNT_W'(HOLD_CYCLES - 1)) ? RELEASE : HOLD;
                cnt_d   = (cnt_q == CNT_W'(HOLD_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
            end
            RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (rel_hit[NUM_DOMAINS-1]) begin
                    state_d   = RUN;
                    cc_d      = '0;
                    running_d = 1'b1;
                end
            end
            RUN: begin
                cc_d = (&cc_q) ? cc_q : cc_q + BUDGET_W'(1);
                if (halt_req || expire) begin
                    state_d     = DONE;
                    running_d   = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = !halt_req;
                    cpu_reset_d = '1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            budget_q    <= '0;
            cc_q        <= '0;
            cpu_reset_q <= '1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            budget_q    <= budget_d;
            cc_q        <= cc_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cc_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: randomized sequences on two configurations, checked against a timeline model.
module tb_mips_run_ctrl;
    logic        clk = 1'b0;
    logic [1:0]  rst_n, start, halt;
    logic [31:0] budget;
    logic [1:0]  cpu0;
    logic        run0, done0, to0;
    logic [31:0] cc0;
    logic [3:0]  cpu1;
    logic        run1, done1, to1;
    logic [3:0]  cc1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mips_run_ctrl u0 (
        .clk(clk), .reset(rst_n[0]), .start(start[0]), .budget(budget), .halt_req(halt[0]),
        .cpu_reset(cpu0), .running(run0), .done(done0), .timeout(to0), .cycle_count(cc0)
    );

    mips_run_ctrl #(.NUM_DOMAINS(4), .HOLD_CYCLES(3), .STAGGER(3), .BUDGET_W(4)) u1 (
        .clk(clk), .reset(rst_n[1]), .start(start[1]), .budget(budget[3:0]), .halt_req(halt[1]),
        .cpu_reset(cpu1), .running(run1), .done(done1), .timeout(to1), .cycle_count(cc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic obs(input int d, input logic [31:0] ecpu, input logic erun, input logic edone,
                       input logic eto, input logic [31:0] ecc);
        chk(d ? "u1.cpu_reset" : "u0.cpu_reset", d ? 32'(cpu1) : 32'(cpu0), ecpu);
        chk(d ? "u1.running" : "u0.running", d ? 32'(run1) : 32'(run0), 32'(erun));
        chk(d ? "u1.done" : "u0.done", d ? 32'(done1) : 32'(done0), 32'(edone));
        chk(d ? "u1.timeout" : "u0.timeout", d ? 32'(to1) : 32'(to0), 32'(eto));
        chk(d ? "u1.cycle_count" : "u0.cycle_count", d ? 32'(cc1) : cc0, ecc);
    endtask

    // Timeline model: edge 0 samples start; c is the RUN cycle_count value at which halt is seen (-1 = none).
    task automatic run(input int d, input longint b, input int c);
        int     n = d ? 4 : 2;
        int     h = d ? 3 : 2;
        int     s = d ? 3 : 1;
        int     w = d ? 4 : 32;
        longint r = h + 1 + (n - 1) * s;
        longint mx = (64'd1 << w) - 1;
        longint eh = (c >= 0) ? r + c + 1 : 64'd1 << 40;
        longint eb = (b != 0) ? r + b : 64'd1 << 40;
        longint e = eh <= eb ? eh : eb;
        bit     to = eb < eh;
        longint ecc_end = (e - r) > mx ? mx : e - r;
        logic [31:0] ecpu;
        longint ecc;
        for (int t = 0; t <= e + 2; t++) begin
            @(negedge clk);
            start[d] = (t == 0) || (t <= e && $urandom_range(0, 7) == 0);
            budget   = (t == 0) ? 32'(b) : $urandom;
            halt[d]  = (c >= 0 && t == r + c + 1) || (t <= r && $urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            ecpu = '0;
            for (int i = 0; i < n; i++) ecpu[i] = !(t >= h + 1 + i * s && t < e);
            ecc = t < r ? 0 : t < e ? ((t - r) > mx ? mx : t - r) : ecc_end;
            obs(d, ecpu, t >= r && t < e, t >= e, t >= e && to, 32'(ecc));
        end
        @(negedge clk);
        start[d] = 1'b0;
        halt[d]  = 1'b0;
    endtask

    task automatic mid_release_reset();
        @(negedge clk);
        start[1] = 1'b1;
        budget   = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start[1] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("u1.cpu_reset after domain1 release", 32'(cpu1), 32'hc);
        #2;
        rst_n[1] = 1'b0;
        #1;
        obs(1, 32'hf, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        obs(1, 32'hf, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_n  = '0;
        start  = '0;
        halt   = '0;
        budget = '0;
        repeat (3) @(posedge clk);
        #1;
        obs(0, 32'h3, 1'b0, 1'b0, 1'b0, 32'd0);
        obs(1, 32'hf, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = '1;
        repeat (10) @(posedge clk);
        #1;
        obs(0, 32'h3, 1'b0, 1'b0, 1'b0, 32'd0);
        obs(1, 32'hf, 1'b0, 1'b0, 1'b0, 32'd0);
        run(0, 500, -1);
        run(0, 500, 37);
        run(0, 10, 9);
        run(0, 0, 30);
        for (int k = 0; k < 6; k++) begin
            int b = int'($urandom_range(0, 40));
            int c = int'($urandom_range(0, 50)) - 1;
            run(0, b, (b == 0 && c < 0) ? 5 : c);
        end
        run(1, 0, 25);
        run(1, 10, -1);
        mid_release_reset();
        run(1, 7, 3);
        for (int k = 0; k < 5; k++) begin
            int b = int'($urandom_range(0, 15));
            int c = int'($urandom_range(0, 30)) - 1;
            run(1, b, (b == 0 && c < 0) ? 20 : c);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
